// File: rtl/pll_freq_checker.sv
// -----------------------------------------------------------------------------
// pll_freq_checker
//
// Purpose:
//   Watches the icebreaker PLL. It filters the asynchronous PLL lock flag. It
//   also measures the PLL frequency by counting rising edges of a divided probe
//   clock over a fixed window of reference clock cycles. Status is reported
//   for the top-level LEDs and for the PLL bench.
//
//   Sequencing:
//     WAIT_LOCK -> SETTLE (GATE_CYCLES) -> MEASURE (GATE_CYCLES) -> EVAL
//     EVAL returns to MEASURE, so measurements repeat back to back.
//   Losing lock in any state other than WAIT_LOCK aborts the window,
//   clears FREQ_OK and latches ERR_STICKY.
//
// Optional feature macro:
//   PLL_LOSS_COUNT_EN - when defined, LOSS_COUNT counts lock-loss events. The
//                       count saturates at 255 and only reset clears it. When
//                       the macro is undefined, LOSS_COUNT is tied to 0.
//
// Ports:
//   CLK         in   reference clock (12 MHz board oscillator)
//   RESET_N     in   asynchronous active-low reset
//   PLL_LOCK    in   PLL lock flag, asynchronous to CLK
//   PROBE       in   divided PLL clock (toggle), asynchronous to CLK
//   CLR_ERR     in   single-cycle pulse that clears ERR_STICKY
//   LOCK_OK     out  filtered lock status
//   FREQ_OK     out  last measurement within tolerance
//   ERR_STICKY  out  latched error flag (a set wins over CLR_ERR)
//   MEAS_VALID  out  one-cycle pulse when MEAS_COUNT updates
//   MEAS_COUNT  out  edge count of the last completed window
//   LOSS_COUNT  out  lock-loss event count (0 unless PLL_LOSS_COUNT_EN)
// -----------------------------------------------------------------------------
module pll_freq_checker #(
  parameter int GATE_CYCLES = 1200,
  parameter int EXPECTED    = 38,
  parameter int TOLERANCE   = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_FILT   = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             PLL_LOCK,
  input  logic             PROBE,
  input  logic             CLR_ERR,
  output logic             LOCK_OK,
  output logic             FREQ_OK,
  output logic             ERR_STICKY,
  output logic             MEAS_VALID,
  output logic [CNT_W-1:0] MEAS_COUNT,
  output logic [7:0]       LOSS_COUNT
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int LF_W = $clog2(LOCK_FILT + 1);

  localparam logic [LF_W-1:0]         LOCK_FILT_V = LF_W'(LOCK_FILT);
  localparam logic [CNT_W-1:0]        GATE_LAST_V = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]        EDGE_MAX_V  = {CNT_W{1'b1}};
  localparam logic signed [CNT_W:0]   EXP_V       = (CNT_W + 1)'(EXPECTED);
  localparam logic [CNT_W:0]          TOL_V       = (CNT_W + 1)'(TOLERANCE);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] SETTLE    = 2'd1;
  localparam logic [1:0] MEASURE   = 2'd2;
  localparam logic [1:0] EVAL      = 2'd3;

  // |count - EXPECTED| <= TOLERANCE. The count is zero-extended by one bit
  // so that the difference cannot wrap for any count value.
  function automatic logic within_tol(input logic [CNT_W-1:0] cnt);
    logic signed [CNT_W:0] diff;
    logic        [CNT_W:0] mag;
    diff = $signed({1'b0, cnt}) - EXP_V;
    if (diff[CNT_W]) begin
      mag = $unsigned(-diff);
    end else begin
      mag = $unsigned(diff);
    end
    return (mag <= TOL_V);
  endfunction

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic             lock_meta_r;
  logic             lock_sync_r;
  logic             probe_meta_r;
  logic             probe_sync_r;
  logic             probe_prev_r;
  logic             probe_rise_s;

  logic [LF_W-1:0]  lock_cnt_r;
  logic             lock_ok_r;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] gate_cnt_r;
  logic [CNT_W-1:0] gate_cnt_nxt_s;
  logic [CNT_W-1:0] edge_cnt_r;
  logic [CNT_W-1:0] edge_cnt_nxt_s;
  logic             eval_s;
  logic             loss_s;
  logic             tol_ok_s;
  logic             err_set_s;

  logic             freq_ok_r;
  logic             err_sticky_r;
  logic             meas_valid_r;
  logic [CNT_W-1:0] meas_count_r;

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------

  // Two-flop synchroniser for the asynchronous lock flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= PLL_LOCK;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Two-flop synchroniser for the probe, plus a history flop for edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      probe_meta_r <= 1'b0;
      probe_sync_r <= 1'b0;
      probe_prev_r <= 1'b0;
    end else begin
      probe_meta_r <= PROBE;
      probe_sync_r <= probe_meta_r;
      probe_prev_r <= probe_sync_r;
    end
  end

  // The edge is visible the cycle after the synchroniser output rises. It is
  // counted on the following clock edge, three clocks after PROBE moved.
  assign probe_rise_s = probe_sync_r & ~probe_prev_r;

  // ---------------------------------------------------------------------------
  // Lock filter
  // ---------------------------------------------------------------------------

  // Saturating run-length counter of high lock samples. LOCK_OK asserts
  // together with the counter reaching LOCK_FILT. One low sample clears both.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lock_cnt_r <= '0;
      lock_ok_r  <= 1'b0;
    end else if (lock_sync_r) begin
      if (lock_cnt_r != LOCK_FILT_V) begin
        lock_cnt_r <= lock_cnt_r + LF_W'(1);
        lock_ok_r  <= ((lock_cnt_r + LF_W'(1)) == LOCK_FILT_V);
      end else begin
        lock_cnt_r <= lock_cnt_r;
        lock_ok_r  <= 1'b1;
      end
    end else begin
      lock_cnt_r <= '0;
      lock_ok_r  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement sequencer
  // ---------------------------------------------------------------------------

  // Next-state, window counter and edge counter decisions.
  always_comb begin
    state_nxt_s    = state_r;
    gate_cnt_nxt_s = gate_cnt_r;
    edge_cnt_nxt_s = edge_cnt_r;
    eval_s         = 1'b0;
    loss_s         = 1'b0;

    if ((state_r != WAIT_LOCK) && !lock_ok_r) begin
      // Lock loss overrides everything, including a pending EVAL.
      loss_s         = 1'b1;
      state_nxt_s    = WAIT_LOCK;
      gate_cnt_nxt_s = '0;
      edge_cnt_nxt_s = '0;
    end else begin
      case (state_r)
        WAIT_LOCK: begin
          gate_cnt_nxt_s = '0;
          edge_cnt_nxt_s = '0;
          if (lock_ok_r) begin
            state_nxt_s = SETTLE;
          end else begin
            state_nxt_s = WAIT_LOCK;
          end
        end

        SETTLE: begin
          // Edges are ignored while the PLL output settles.
          edge_cnt_nxt_s = '0;
          if (gate_cnt_r == GATE_LAST_V) begin
            state_nxt_s    = MEASURE;
            gate_cnt_nxt_s = '0;
          end else begin
            state_nxt_s    = SETTLE;
            gate_cnt_nxt_s = gate_cnt_r + CNT_W'(1);
          end
        end

        MEASURE: begin
          // The final window cycle still counts an edge.
          if (probe_rise_s && (edge_cnt_r != EDGE_MAX_V)) begin
            edge_cnt_nxt_s = edge_cnt_r + CNT_W'(1);
          end else begin
            edge_cnt_nxt_s = edge_cnt_r;
          end
          if (gate_cnt_r == GATE_LAST_V) begin
            state_nxt_s    = EVAL;
            gate_cnt_nxt_s = '0;
          end else begin
            state_nxt_s    = MEASURE;
            gate_cnt_nxt_s = gate_cnt_r + CNT_W'(1);
          end
        end

        EVAL: begin
          // Publish the result. The counters restart, so an edge arriving
          // in this cycle is dropped.
          eval_s         = 1'b1;
          state_nxt_s    = MEASURE;
          gate_cnt_nxt_s = '0;
          edge_cnt_nxt_s = '0;
        end

        default: begin
          state_nxt_s    = WAIT_LOCK;
          gate_cnt_nxt_s = '0;
          edge_cnt_nxt_s = '0;
        end
      endcase
    end
  end

  // Sequencer state and counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r    <= WAIT_LOCK;
      gate_cnt_r <= '0;
      edge_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      gate_cnt_r <= gate_cnt_nxt_s;
      edge_cnt_r <= edge_cnt_nxt_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Result and status registers
  // ---------------------------------------------------------------------------

  assign tol_ok_s  = within_tol(edge_cnt_r);
  assign err_set_s = (eval_s && !tol_ok_s) || loss_s;

  // Measurement result, its valid pulse and the frequency status.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      meas_valid_r <= 1'b0;
      meas_count_r <= '0;
      freq_ok_r    <= 1'b0;
    end else begin
      meas_valid_r <= eval_s;
      if (eval_s) begin
        meas_count_r <= edge_cnt_r;
        freq_ok_r    <= tol_ok_s;
      end else if (loss_s) begin
        // MEAS_COUNT keeps the last good value across a lock loss.
        meas_count_r <= meas_count_r;
        freq_ok_r    <= 1'b0;
      end else begin
        meas_count_r <= meas_count_r;
        freq_ok_r    <= freq_ok_r;
      end
    end
  end

  // Sticky error flag. A set in the same cycle as CLR_ERR takes priority.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_sticky_r <= 1'b0;
    end else if (err_set_s) begin
      err_sticky_r <= 1'b1;
    end else if (CLR_ERR) begin
      err_sticky_r <= 1'b0;
    end else begin
      err_sticky_r <= err_sticky_r;
    end
  end

`ifdef PLL_LOSS_COUNT_EN
  logic [7:0] loss_cnt_r;

  // Saturating count of lock-loss events. Only reset clears it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      loss_cnt_r <= 8'd0;
    end else if (loss_s && (loss_cnt_r != 8'hFF)) begin
      loss_cnt_r <= loss_cnt_r + 8'd1;
    end else begin
      loss_cnt_r <= loss_cnt_r;
    end
  end

  assign LOSS_COUNT = loss_cnt_r;
`else
  assign LOSS_COUNT = 8'd0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign LOCK_OK    = lock_ok_r;
  assign FREQ_OK    = freq_ok_r;
  assign ERR_STICKY = err_sticky_r;
  assign MEAS_VALID = meas_valid_r;
  assign MEAS_COUNT = meas_count_r;

endmodule

// File: doc/pll_freq_checker.md
Name: pll_freq_checker

Overview:
Checks the icebreaker PLL output and sits directly downstream of the PLL test stage. It filters the PLL LOCK flag. It also counts edges of a divided PLL probe signal over a fixed window of reference CLK cycles and flags whether the PLL frequency is inside tolerance. Status outputs feed the LED mapping in the top level and the PLL testbench checks.

Parameters:
GATE_CYCLES, 1200, length of the settle and measure windows in CLK cycles (100 us at 12 MHz)
EXPECTED, 38, expected rising PROBE edges per measure window
TOLERANCE, 2, allowed absolute deviation from EXPECTED
CNT_W, 16, width of edge and window counters
LOCK_FILT, 16, consecutive high LOCK samples required before lock is accepted

Ports:
CLK  in  1  reference clock (12 MHz board oscillator)
RESET_N  in  1  asynchronous active-low reset
PLL_LOCK  in  1  PLL lock flag, asynchronous to CLK
PROBE  in  1  divided PLL clock (toggle), asynchronous to CLK
CLR_ERR  in  1  single-cycle pulse that clears ERR_STICKY
LOCK_OK  out  1  filtered lock status
FREQ_OK  out  1  last measurement within tolerance
ERR_STICKY  out  1  latched error flag
MEAS_VALID  out  1  one-cycle pulse when MEAS_COUNT updates
MEAS_COUNT  out  CNT_W  edge count of the last completed window
LOSS_COUNT  out  8  lock-loss event count (optional feature)

Behaviour:
- One clock, CLK. RESET_N is asynchronous and active-low. Every flop clears when RESET_N is low.
- Reset values: all outputs 0. FSM is in WAIT_LOCK.
- Synchronisers:
  - PLL_LOCK passes through 2 flops.
  - PROBE passes through 2 flops plus a third flop for edge detection.
  - A rising edge is synced=1 and previous=0.
  - PROBE edge-to-count latency is 3 CLK cycles.
- Lock filter:
  - A counter increments while synced lock is 1 and saturates at LOCK_FILT.
  - LOCK_OK goes to 1 in the cycle the counter reaches LOCK_FILT.
  - Any sample of 0 clears the counter and drops LOCK_OK in the next cycle.
- FSM states:
  - WAIT_LOCK: counters held at 0. Moves to SETTLE when LOCK_OK=1.
  - SETTLE: counts GATE_CYCLES cycles and ignores edges. Then moves to MEASURE.
  - MEASURE: a window counter runs 0..GATE_CYCLES-1. The edge counter increments on each detected rising edge and saturates at all-ones. An edge in the final MEASURE cycle is counted. After the final cycle the FSM moves to EVAL.
  - EVAL, one cycle:
    - MEAS_COUNT is loaded and MEAS_VALID pulses for 1 cycle.
    - FREQ_OK is set to (|count-EXPECTED| <= TOLERANCE), computed with CNT_W+1 bit signed difference.
    - ERR_STICKY sets if the result is not OK.
    - Counters clear and the FSM returns to MEASURE.
    - An edge arriving during EVAL is dropped (this is decided behaviour).
- Lock loss: LOCK_OK falling in any state other than WAIT_LOCK has these effects on the next cycle:
  - FSM goes to WAIT_LOCK and counters clear.
  - FREQ_OK clears. MEAS_COUNT holds its last value. No MEAS_VALID pulse.
  - ERR_STICKY sets.
- ERR_STICKY clears on CLR_ERR=1. If a set and a clear happen in the same cycle, the set wins.
- RESET_N asserted mid-window: the partial count is discarded, with no MEAS_VALID.

Optional Feature:
PLL_LOSS_COUNT_EN
- Defined: LOSS_COUNT increments by 1 on each lock-loss event as defined above. It saturates at 255 and is cleared only by reset; CLR_ERR does not affect it.
- Undefined: LOSS_COUNT is tied to 0 and no counter logic is generated.

Test Plan:
1. GATE_CYCLES=100, EXPECTED=25, TOLERANCE=1, LOCK_FILT=4. PLL_LOCK high from cycle 10, PROBE period 4 cycles -> LOCK_OK rises about cycle 16. First MEAS_VALID follows after 100 settle + 100 measure cycles with MEAS_COUNT=25, FREQ_OK=1, ERR_STICKY=0.
2. Same configuration, PROBE period 5 -> MEAS_COUNT=20, FREQ_OK=0, ERR_STICKY=1. Then CLR_ERR pulse -> ERR_STICKY=0. The next window sets it again.
3. PLL_LOCK glitch high for 3 cycles (LOCK_FILT=4) -> LOCK_OK stays 0, FSM stays in WAIT_LOCK, no MEAS_VALID.
4. PLL_LOCK dropped at cycle 50 of MEASURE -> LOCK_OK=0, FREQ_OK=0, ERR_STICKY=1, no MEAS_VALID, MEAS_COUNT unchanged. With PLL_LOSS_COUNT_EN, LOSS_COUNT=1. Relock restarts with SETTLE.
5. CLR_ERR in the same cycle as a failing EVAL -> ERR_STICKY=1. RESET_N low mid-MEASURE -> all outputs 0 asynchronously. After release, operation restarts from WAIT_LOCK.
6. PROBE edges at windows {0,1,...,19} cycles apart such that an edge falls on the final MEASURE cycle and another on EVAL -> the first is counted and the second dropped. Verify MEAS_COUNT exactly.
